if_fetch_unit: RTL

//  Instruction-fetch stage: owns the PC register, issues in-order reads to instruction memory,

---
 rtl/if_fetch_unit_pkg.sv | 25 ++
 rtl/if_fetch_unit_if.sv | 33 +++
 rtl/if_fetch_unit_fifo.sv | 80 ++++++++
 rtl/if_fetch_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_fetch_pkg
// Brief   : Shared types and constants for the instruction-fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
package riscv_fetch_pkg;

    localparam int          FETCH_PC_W = 9;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_PC_W-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_unit_if
// Brief   : Redirect, instruction-memory and decode-side signals of the fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
interface if_fetch_unit_if #(
    parameter int PC_W = 9
);
    logic            PcSel;
    logic [31:0]     BrPC;
    logic            id_stall;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            if_valid;
    logic [PC_W-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            misalign_err;

    // master = fetch unit, slave = branch unit / memory / decode environment
    modport master (
        input  PcSel, BrPC, id_stall, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, if_valid, if_pc, if_instr, misalign_err
    );

    modport slave (
        output PcSel, BrPC, id_stall, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, if_valid, if_pc, if_instr, misalign_err
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fetch_fifo
// Brief   : Synchronous {pc, instr} buffer; flush beats push and pop.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [PC_W-1:0]              push_pc_i,
    input  logic [31:0]                  push_instr_i,
    output logic [PC_W-1:0]              head_pc_o,
    output logic [31:0]                  head_instr_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PC_W-1:0]  pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    // A push into a full buffer is legal only when the head leaves the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                pc_mem_q[wr_ptr_q]    <= push_pc_i;
                instr_mem_q[wr_ptr_q] <= push_instr_i;
                wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_pc_o    = pc_mem_q[rd_ptr_q];
    assign head_instr_o = instr_mem_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_unit
// Brief   : PC owner, in-order imem requester and fetch buffer feeding decode.
//           Optional macro FETCH_MISALIGN_CHK_EN halts on a misaligned redirect.
// Revision: 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int              PC_W       = 9,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    if_fetch_unit_if.master bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    fetch_state_e     state_q;
    logic [PC_W-1:0]  pc_q;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] outstanding_d;
    logic [CNT_W-1:0] discard_q;
    logic             misalign_q;

    logic             redirect;
    logic             misalign;
    logic [PC_W-1:0]  target;
    logic             rsp;
    logic             do_req;
    logic             do_push;
    logic             do_pop;
    logic [CNT_W:0]   used;
    logic [PC_W-1:0]  rsp_pc;
    logic [PC_W-1:0]  head_pc;
    logic [31:0]      head_instr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_valid;
    logic             unused_bits;

    assign redirect = bus.PcSel && (state_q != S_HALT);

`ifdef FETCH_MISALIGN_CHK_EN
    assign misalign    = redirect && (bus.BrPC[1:0] != 2'b00);
    assign target      = bus.BrPC[PC_W-1:0];
    assign unused_bits = ^{bus.BrPC[31:PC_W], fifo_full};
`else
    assign misalign    = 1'b0;
    assign target      = {bus.BrPC[PC_W-1:2], 2'b00};
    assign unused_bits = ^{bus.BrPC[31:PC_W], bus.BrPC[1:0], fifo_full};
`endif

    assign fifo_valid = !fifo_empty;
    assign rsp        = bus.imem_rvalid && (outstanding_q != '0);
    assign do_pop     = fifo_valid && !bus.id_stall && !bus.PcSel;

    // The slot freed by this cycle's pop counts as credit, sustaining one word per cycle.
    assign used    = {1'b0, outstanding_q} + {1'b0, fifo_count} - {{CNT_W{1'b0}}, do_pop};
    assign do_req  = (state_q == S_FETCH) && !bus.PcSel && (used < (CNT_W+1)'(FIFO_DEPTH));
    assign do_push = (state_q == S_FETCH) && rsp && !redirect;

    assign outstanding_d = outstanding_q + CNT_W'(do_req) - CNT_W'(rsp);
    // Oldest in-flight address: pc has advanced once per outstanding request.
    assign rsp_pc        = pc_q - (PC_W'(outstanding_q) << 2);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .PC_W  (PC_W)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (do_push),
        .pop_i        (do_pop),
        .flush_i      (redirect),
        .push_pc_i    (rsp_pc),
        .push_instr_i (bus.imem_rdata),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr),
        .count_o      (fifo_count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            misalign_q    <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            if (misalign) begin
                misalign_q <= 1'b1;
                discard_q  <= '0;
                state_q    <= S_HALT;
            end else if (redirect) begin
                pc_q      <= target;
                discard_q <= outstanding_d;
                state_q   <= (outstanding_d != '0) ? S_DRAIN : S_FETCH;
            end else begin
                case (state_q)
                    S_BOOT:  state_q <= S_FETCH;
                    S_FETCH: if (do_req) pc_q <= pc_q + PC_W'(4);
                    S_DRAIN: begin
                        if (rsp) discard_q <= discard_q - CNT_W'(1);
                        if (discard_q == CNT_W'(rsp)) state_q <= S_FETCH;
                    end
                    S_HALT:  state_q <= S_HALT;
                    default: state_q <= S_BOOT;
                endcase
            end
        end
    end

    assign bus.imem_req     = do_req;
    assign bus.imem_addr    = pc_q;
    assign bus.if_valid     = fifo_valid;
    assign bus.if_pc        = fifo_valid ? head_pc    : '0;
    assign bus.if_instr     = fifo_valid ? head_instr : '0;
    assign bus.misalign_err = misalign_q;

endmodule
`default_nettype wire
